// File: rtl/branch_predictor_if.sv
// Fetch/execute-side signal bundle for the branch predictor.
// master = core side (fetch + execute), slave = predictor.
interface branch_predictor_if;
   logic        f_valid;
   logic [31:0] f_pc;
   logic        pred_valid;
   logic        pred_hit;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        u_valid;
   logic [31:0] u_pc;
   logic        u_taken;
   logic [31:0] u_target;
   logic        u_pred_taken;
   logic        flush;
   logic [15:0] mispredict_cnt;

   modport master (
      output f_valid, f_pc, u_valid, u_pc, u_taken, u_target, u_pred_taken, flush,
      input  pred_valid, pred_hit, pred_taken, pred_target, mispredict_cnt
   );

   modport slave (
      input  f_valid, f_pc, u_valid, u_pc, u_taken, u_target, u_pred_taken, flush,
      output pred_valid, pred_hit, pred_taken, pred_target, mispredict_cnt
   );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters: one-cycle registered lookup,
// execute-side training/allocation, whole-table flush and a misprediction counter.
module branch_predictor #(
   parameter int INDEX_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   branch_predictor_if.slave  bus
);
   localparam int ENTRIES = 2 ** INDEX_W;
   localparam int TAG_W   = 30 - INDEX_W;

   logic [ENTRIES-1:0] r_valid;
   logic [1:0]         r_ctr    [ENTRIES];
   logic [TAG_W-1:0]   r_tag    [ENTRIES];
   logic [31:0]        r_target [ENTRIES];

   logic        r_pred_valid;
   logic        r_pred_hit;
   logic        r_pred_taken;
   logic [31:0] r_pred_target;
   logic [15:0] r_mispredict_cnt;

   logic [INDEX_W-1:0] w_f_idx;
   logic [TAG_W-1:0]   w_f_tag;
   logic               w_f_hit;
   logic               w_f_taken;
   logic [31:0]        w_f_target;

   logic [INDEX_W-1:0] w_u_idx;
   logic [TAG_W-1:0]   w_u_tag;
   logic               w_u_hit;
   logic               w_u_train;
   logic               w_u_alloc;
   logic [1:0]         w_ctr_cur;
   logic [1:0]         w_ctr_next;
   logic               w_mispredict;

   // Byte-offset bits of the PCs never address the table.
   logic w_unused_pc_lsbs;
   assign w_unused_pc_lsbs = ^{bus.f_pc[1:0], bus.u_pc[1:0]};

   assign w_f_idx    = bus.f_pc[INDEX_W+1:2];
   assign w_f_tag    = bus.f_pc[31:INDEX_W+2];
   assign w_f_hit    = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
   assign w_f_taken  = w_f_hit && r_ctr[w_f_idx][1];
   assign w_f_target = w_f_taken ? r_target[w_f_idx] : (bus.f_pc + 32'd4);

   assign w_u_idx      = bus.u_pc[INDEX_W+1:2];
   assign w_u_tag      = bus.u_pc[31:INDEX_W+2];
   assign w_u_hit      = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);
   assign w_u_train    = bus.u_valid && !bus.flush && w_u_hit;
   assign w_u_alloc    = bus.u_valid && !bus.flush && !w_u_hit && bus.u_taken;
   assign w_ctr_cur    = r_ctr[w_u_idx];
   assign w_mispredict = bus.u_valid && (bus.u_taken != bus.u_pred_taken);

   always_comb begin
      w_ctr_next = w_ctr_cur;
      if (bus.u_taken) begin
         if (w_ctr_cur != 2'b11) w_ctr_next = w_ctr_cur + 2'd1;
      end else begin
         if (w_ctr_cur != 2'b00) w_ctr_next = w_ctr_cur - 2'd1;
      end
   end

   // Valid bits and counters carry reset state; tags/targets are qualified by valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= '0;
         for (int i = 0; i < ENTRIES; i++) r_ctr[i] <= 2'b01;
      end else begin
         if (bus.flush)     r_valid <= '0;
         else if (w_u_alloc) r_valid[w_u_idx] <= 1'b1;

         if (w_u_alloc)      r_ctr[w_u_idx] <= 2'b10;
         else if (w_u_train) r_ctr[w_u_idx] <= w_ctr_next;
      end
   end

   always_ff @(posedge clk) begin
      if (w_u_alloc) begin
         r_tag[w_u_idx]    <= w_u_tag;
         r_target[w_u_idx] <= bus.u_target;
      end else if (w_u_train && bus.u_taken) begin
         r_target[w_u_idx] <= bus.u_target;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pred_valid  <= 1'b0;
         r_pred_hit    <= 1'b0;
         r_pred_taken  <= 1'b0;
         r_pred_target <= 32'd0;
      end else if (bus.f_valid) begin
         r_pred_valid  <= 1'b1;
         r_pred_hit    <= w_f_hit;
         r_pred_taken  <= w_f_taken;
         r_pred_target <= w_f_target;
      end else begin
         r_pred_valid  <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)               r_mispredict_cnt <= 16'd0;
      else if (w_mispredict) r_mispredict_cnt <= r_mispredict_cnt + 16'd1;
   end

   assign bus.pred_valid     = r_pred_valid;
   assign bus.pred_hit       = r_pred_hit;
   assign bus.pred_taken     = r_pred_taken;
   assign bus.pred_target    = r_pred_target;
   assign bus.mispredict_cnt = r_mispredict_cnt;
endmodule

// File: doc/branch_predictor.md
# branch_predictor

Fetch-stage branch predictor and branch target buffer (BTB) for the RISC-V core. It closes the loop opposite the execute-stage branch resolution: execute reports each resolved conditional branch (outcome, target, and what was predicted), and fetch queries with the current PC for a taken/not-taken prediction and the next-PC target. Storage is direct-mapped: one tag, one target and one 2-bit saturating counter per entry. The block also keeps a misprediction counter for performance debug.

## Interface
Parameters:
- INDEX_W, 4, index width; the table holds 2**INDEX_W entries.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- f_valid  in  1  fetch lookup request this cycle.
- f_pc  in  32  fetch PC to look up.
- pred_valid  out  1  registered; the prediction outputs carry the result of last cycle's request.
- pred_hit  out  1  registered; the looked-up PC had a valid entry with a matching tag.
- pred_taken  out  1  registered; predicted taken.
- pred_target  out  32  registered; predicted next PC.
- u_valid  in  1  resolved conditional branch from execute this cycle.
- u_pc  in  32  PC of the resolved branch.
- u_taken  in  1  actual outcome (the branch unit's taken result).
- u_target  in  32  computed branch target.
- u_pred_taken  in  1  prediction that was issued for this branch.
- flush  in  1  synchronously invalidates the whole table.
- mispredict_cnt  out  16  count of mispredicted branches.

## Operation
- Address split:
  - index = pc[INDEX_W+1:2].
  - tag = pc[31:INDEX_W+2].
  - pc[1:0] is ignored.
- Per-entry state: valid, tag, target[31:0], ctr[1:0].
  - ctr 00 = strongly not-taken, 01 = weakly not-taken, 10 = weakly taken, 11 = strongly taken.
- Lookup (on an edge where f_valid=1):
  - hit = valid[idx] && tag[idx]==tag(f_pc).
  - pred_hit <= hit.
  - pred_taken <= hit && ctr[idx][1].
  - pred_target <= pred_taken ? target[idx] : f_pc+4, where pred_taken is the value being registered. The +4 wraps modulo 2^32.
  - pred_valid <= 1.
- Lookup (on an edge where f_valid=0): pred_valid <= 0; pred_hit, pred_taken and pred_target hold.
- Update (on an edge where u_valid=1), indexed by u_pc:
  - Tag hit:
    - ctr saturating-increments if u_taken=1, saturating-decrements if u_taken=0.
    - If u_taken=1, target <= u_target.
    - Tag is unchanged.
  - Tag miss, u_taken=1: allocate and replace whatever is there. valid<=1, tag<=tag(u_pc), target<=u_target, ctr<=10.
  - Tag miss, u_taken=0: no table change.
- Misprediction counter: on an edge where u_valid=1 and u_taken!=u_pred_taken, mispredict_cnt increments by 1. It wraps from 0xFFFF to 0x0000.
- Flush:
  - All valid bits clear on that edge.
  - Flush takes priority over an update in the same cycle; that update is dropped from the table.
  - mispredict_cnt still counts that update.
  - Counters and targets are left as they are.
- Read-before-write: a lookup always sees the table state from before the current edge. This holds for a same-cycle update or flush to the same index.

## Timing
- Lookup latency: 1 cycle. A request at edge N is visible on the pred_* outputs after edge N. A new request can be accepted every cycle.
- Update latency: the table changes at edge N. The change is visible to a lookup registered at edge N+1 or later.
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - All valid bits 0; all ctr 01.
  - pred_valid=0, pred_hit=0, pred_taken=0, pred_target=0.
  - mispredict_cnt=0.
  - Tags and targets are don't-care, since valid=0.
- Reset release: the first request is accepted on the first rising edge with rst=0.
- Simultaneous f_valid and u_valid are always legal; there is no stall or back-pressure on either side.

## Test plan
1. Reset, then lookup with f_pc=0x100 → next cycle pred_valid=1, hit=0, taken=0, target=0x104; mispredict_cnt=0.
2. Update u_pc=0x100, taken=1, target=0x80, u_pred_taken=0, then lookup 0x100 → hit=1, taken=1, target=0x80; mispredict_cnt=1.
3. Counter saturation on entry 0x100:
   - From ctr 10, two not-taken updates → lookup gives taken=0, target=0x104.
   - One further not-taken update → still not-taken.
   - Four taken updates → ctr 11.
   - One not-taken update → ctr 10, lookup still taken=1.
4. Aliasing:
   - Taken update u_pc=0x140 (same index as 0x100, different tag), target=0x200 → lookup 0x140 gives hit=1, target=0x200; lookup 0x100 gives hit=0, target=0x104.
   - A not-taken update on a different aliasing PC, 0x180 → lookup 0x140 is unchanged.
5. Same-cycle lookup of 0x300 and first taken update of 0x300 → that lookup returns hit=0; the following lookup returns hit=1.
6. Flush and reset:
   - Flush asserted with a mispredicting update → all lookups miss; mispredict_cnt still increments.
   - Preset 0xFFFF mispredicts → next mispredict wraps the counter to 0.
   - Assert rst between clock edges → outputs go to reset values immediately.
